fft_frame_ctrl: RTL and testbench
=================================

# fft_frame_ctrl

Frame-level sequencer for the pipelined FFT/IFFT stage chain. It accepts a valid/ready sample stream, issues `ien`/`iaddr`/`idata` to the first pipeline stage with frame-aligned addressing, limits frames in flight, and counts pipeline `oen` beats to rebuild frame boundaries and signal completion. It sits between the sample source and the cascaded stage instances, which have no backpressure.

## Interface
- `TOTAL_STAGE_P`, 10, log2 of FFT length N; address width
- `MULT_WIDTH_P`, 18, real/imag width; complex word is 2*`MULT_WIDTH_P` bits, imag in upper half
- `MAX_INFLIGHT_P`, 2, maximum fully-issued frames not yet fully returned (1..15)
- `iclk` input 1 — single clock, all logic rising-edge
- `rst_n` input 1 — asynchronous, active-low reset
- `cfg_start` input 1 — one-cycle pulse; accepted in IDLE only
- `cfg_nframes` input 8 — frame count latched at start
- `cfg_inverse` input 1 — IFFT select, latched at start; used only with `FFT_FRAME_CTRL_IFFT_EN`
- `s_valid` input 1 / `s_ready` output 1 / `s_data` input 2W — input sample stream
- `fft_ien` output 1 / `fft_iaddr` output `TOTAL_STAGE_P` / `fft_idata` output 2W — to pipeline
- `fft_oen` input 1 / `fft_oaddr` input `TOTAL_STAGE_P` / `fft_odata` input 2W — from pipeline
- `m_valid` output 1 / `m_addr` output `TOTAL_STAGE_P` / `m_data` output 2W / `m_last` output 1 — result stream, no ready
- `busy` output 1, `done` output 1 (pulse), `err` output 1 (sticky)

## Operation
- States: IDLE, FEED, DRAIN.
- IDLE → FEED on `cfg_start`, latching `cfg_nframes` and `cfg_inverse`, clearing `err` and all counters. If `cfg_nframes`=0, go IDLE and pulse `done` the next cycle.
- `cfg_start` outside IDLE is ignored.
- FEED, `s_ready` = 1 unless `in_cnt`=0 and `inflight`=`MAX_INFLIGHT_P`. Stalls are possible only at frame starts. Input gaps (`s_valid`=0) are allowed anywhere.
- Each handshake issues one `fft_ien` beat with `fft_iaddr`=`in_cnt`, then increments `in_cnt`, wrapping at N-1.
- On the wrap, increment `frames_sent` and `inflight`. When `frames_sent` equals `nframes`, go FEED → DRAIN.
- Each `fft_oen` produces one `m_valid` beat with `m_addr`=`fft_oaddr` and `m_data`=`fft_odata`, and increments `out_cnt`.
- `m_last`=1 on the beat where `out_cnt`=N-1. That beat increments `frames_recv` and decrements `inflight`. If increment and decrement hit in the same cycle, `inflight` is unchanged.
- If `fft_oaddr` ≠ `out_cnt` on an `fft_oen` beat, set `err` (sticky until next accepted start).
- `fft_oen` while IDLE, or after `frames_recv`=`nframes`, also sets `err`; the data is still forwarded.
- DRAIN → IDLE when `frames_recv` equals `nframes`. `done` pulses in that transition cycle.
- `busy` = state ≠ IDLE.
- Async reset mid-frame: all state is cleared. Partial frames in the pipeline are not tracked; any later `oen` beats set `err`.

## Timing
- Reset values: `s_ready`, `fft_ien`, `m_valid`, `m_last`, `busy`, `done`, `err` = 0; all address and data outputs = 0.
- Input path: `fft_ien`/`fft_iaddr`/`fft_idata` are registered and appear 1 cycle after the `s_valid`&`s_ready` cycle.
- Output path: `m_*` are registered and appear 1 cycle after `fft_oen`.
- `done` is asserted 1 cycle after the final `m_last` beat.
- `s_ready` is combinational from state and counters, with no dependence on `s_valid`.
- Sustained throughput: 1 sample/cycle.

## Configuration
- Macro `FFT_FRAME_CTRL_IFFT_EN` defined:
  - when latched inverse=1, `fft_idata` and `m_data` have real/imag halves swapped (conjugate-swap IFFT);
  - no scaling is applied.
- Macro undefined:
  - `cfg_inverse` is ignored and data passes unmodified;
  - the swap muxes are not built.

## Structure
- Shared package `fft_pkg`:
  - FSM state encoding (IDLE, FEED, DRAIN);
  - complex half-select helpers (real = low `MULT_WIDTH_P` bits, imag = high);
  - the swap function.
- One sub-module, `fft_frame_cnt`: a parameterised wrapping beat counter with a terminal-count flag. It is instantiated twice, for the input and output sides.

## Test plan
- **Reset:** assert `rst_n`=0 mid-FEED with N=16 → next cycle all outputs 0, `busy`=0; a later stray `fft_oen` → `err`=1.
- **Single frame:** N=16, `nframes`=1, contiguous input, pipeline model latency 40 → 16 `fft_ien` beats with addr 0..15; 16 `m_valid` beats, `m_last` on the 16th; `done` 1 cycle later.
- **In-flight limit:** `MAX_INFLIGHT_P`=2, `nframes`=4, pipeline latency 3 frames → `s_ready` low at start of frame 3 until frame 1 `m_last`; no lost or duplicated beats.
- **Input gaps and simultaneous events:** random `s_valid` gaps; frame `m_last` coincides with another frame's last input → `inflight` unchanged; `done` after exactly `nframes` `m_last`.
- **Address check:** inject `fft_oaddr`=5 when 4 is expected → `err`=1 and stays set; cleared by the next `cfg_start`.
- **IFFT (macro defined, inverse=1):** `s_data`={imag=3, real=7} → `fft_idata`={imag=7, real=3}; output swapped likewise. With the macro undefined → data unchanged.

Source files
------------

// File: rtl/fft_pkg.sv
// fft_pkg: FSM state encoding and complex-word half-select and swap helpers
package fft_pkg;
  typedef enum logic [1:0] {IDLE, FEED, DRAIN} state_t;
  localparam int CW_MAX = 128;
  typedef logic [CW_MAX-1:0] cword_t;
  function automatic cword_t half_mask(input int w);
    return (cword_t'(1) << w) - cword_t'(1);
  endfunction
  function automatic cword_t cplx_re(input cword_t x, input int w);
    return x & half_mask(w);
  endfunction
  function automatic cword_t cplx_im(input cword_t x, input int w);
    return (x >> w) & half_mask(w);
  endfunction
  function automatic cword_t cplx_swap(input cword_t x, input int w);
    return (cplx_re(x, w) << w) | cplx_im(x, w);
  endfunction
endpackage

// File: rtl/fft_frame_cnt.sv
// fft_frame_cnt: wrapping beat counter with terminal-count flag at 2**W-1
module fft_frame_cnt #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc
);
  assign tc = &cnt;
  // clear has priority over counting; natural overflow wraps to zero
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt + W'(1);
endmodule

// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: frame sequencer for the FFT pipeline; optional IFFT swap under FFT_FRAME_CTRL_IFFT_EN
module fft_frame_ctrl
  import fft_pkg::*;
#(
  parameter int TOTAL_STAGE_P  = 10,
  parameter int MULT_WIDTH_P   = 18,
  parameter int MAX_INFLIGHT_P = 2
) (
  input  logic                      iclk,
  input  logic                      rst_n,
  input  logic                      cfg_start,
  input  logic [7:0]                cfg_nframes,
  input  logic                      cfg_inverse,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [2*MULT_WIDTH_P-1:0] s_data,
  output logic                      fft_ien,
  output logic [TOTAL_STAGE_P-1:0]  fft_iaddr,
  output logic [2*MULT_WIDTH_P-1:0] fft_idata,
  input  logic                      fft_oen,
  input  logic [TOTAL_STAGE_P-1:0]  fft_oaddr,
  input  logic [2*MULT_WIDTH_P-1:0] fft_odata,
  output logic                      m_valid,
  output logic [TOTAL_STAGE_P-1:0]  m_addr,
  output logic [2*MULT_WIDTH_P-1:0] m_data,
  output logic                      m_last,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);
  localparam int DW = 2*MULT_WIDTH_P;
  localparam logic [3:0] MAX_IF = 4'(MAX_INFLIGHT_P);
  state_t state;
  logic [7:0] nframes, frames_sent, frames_recv;
  logic [3:0] inflight;
  logic [TOTAL_STAGE_P-1:0] in_cnt, out_cnt;
  logic in_tc, out_tc, hs, in_wrap, out_wrap, out_dec, recv_all, bad;
  logic [DW-1:0] in_d, out_d;
  assign busy     = state != IDLE;
  assign s_ready  = state == FEED && !(in_cnt == '0 && inflight == MAX_IF);
  assign hs       = s_valid && s_ready;
  assign in_wrap  = hs && in_tc;
  assign recv_all = frames_recv == nframes;
  assign out_wrap = fft_oen && out_tc && busy && !recv_all;
  assign out_dec  = out_wrap && inflight != '0;
  assign bad      = fft_oen && (!busy || recv_all || fft_oaddr != out_cnt);
  fft_frame_cnt #(.W(TOTAL_STAGE_P)) u_in_cnt (
    .clk(iclk), .rst_n(rst_n), .clr(state == IDLE && cfg_start), .en(hs), .cnt(in_cnt), .tc(in_tc)
  );
  fft_frame_cnt #(.W(TOTAL_STAGE_P)) u_out_cnt (
    .clk(iclk), .rst_n(rst_n), .clr(state == IDLE && cfg_start), .en(fft_oen), .cnt(out_cnt), .tc(out_tc)
  );
`ifdef FFT_FRAME_CTRL_IFFT_EN
  logic inverse;
  assign in_d  = inverse ? DW'(cplx_swap(cword_t'(s_data), MULT_WIDTH_P)) : s_data;
  assign out_d = inverse ? DW'(cplx_swap(cword_t'(fft_odata), MULT_WIDTH_P)) : fft_odata;
  // transform direction is fixed for the whole run at the accepted start
  always_ff @(posedge iclk or negedge rst_n)
    if (!rst_n) inverse <= 1'b0;
    else if (state == IDLE && cfg_start) inverse <= cfg_inverse;
`else
  logic unused_inverse;
  assign unused_inverse = cfg_inverse;
  assign in_d  = s_data;
  assign out_d = fft_odata;
`endif
  // frame sequencing: feed until all frames issued, drain until all returned
  always_ff @(posedge iclk or negedge rst_n)
    if (!rst_n) begin
      state       <= IDLE;
      nframes     <= '0;
      frames_sent <= '0;
      frames_recv <= '0;
      inflight    <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      done <= 1'b0;
      if (bad) err <= 1'b1;
      if (in_wrap) frames_sent <= frames_sent + 8'd1;
      if (out_wrap) frames_recv <= frames_recv + 8'd1;
      inflight <= inflight + 4'(in_wrap) - 4'(out_dec);
      case (state)
        IDLE: if (cfg_start) begin
          nframes     <= cfg_nframes;
          frames_sent <= '0;
          frames_recv <= '0;
          inflight    <= '0;
          err         <= 1'b0;
          if (cfg_nframes == '0) done <= 1'b1;
          else state <= FEED;
        end
        FEED: if (in_wrap && frames_sent + 8'd1 == nframes) state <= DRAIN;
        DRAIN: if (recv_all) begin
          state <= IDLE;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  // registered issue to the first stage and registered result stream
  always_ff @(posedge iclk or negedge rst_n)
    if (!rst_n) begin
      fft_ien   <= 1'b0;
      fft_iaddr <= '0;
      fft_idata <= '0;
      m_valid   <= 1'b0;
      m_addr    <= '0;
      m_data    <= '0;
      m_last    <= 1'b0;
    end else begin
      fft_ien <= hs;
      m_valid <= fft_oen;
      m_last  <= fft_oen && out_tc;
      if (hs) begin
        fft_iaddr <= in_cnt;
        fft_idata <= in_d;
      end
      if (fft_oen) begin
        m_addr <= fft_oaddr;
        m_data <= out_d;
      end
    end
endmodule

// File: tb/tb_fft_frame_ctrl.sv
// tb_fft_frame_ctrl: self-checking bench with a frame-count reference model and pipeline delay model
module tb_fft_frame_ctrl;
  localparam int TS = 4;
  localparam int MW = 8;
  localparam int N = 16;
  localparam int MAXI = 2;
`ifdef FFT_FRAME_CTRL_IFFT_EN
  localparam bit IFFT = 1'b1;
`else
  localparam bit IFFT = 1'b0;
`endif
  logic iclk = 1'b0, rst_n = 1'b0;
  logic cfg_start = 1'b0, cfg_inverse = 1'b0, s_valid = 1'b0, fft_oen = 1'b0;
  logic [7:0] cfg_nframes = '0;
  logic [15:0] s_data = '0, fft_odata = '0;
  logic [TS-1:0] fft_oaddr = '0;
  logic s_ready, fft_ien, m_valid, m_last, busy, done, err;
  logic [TS-1:0] fft_iaddr, m_addr;
  logic [15:0] fft_idata, m_data;
  int checks = 0, errors = 0, cyc = 0;
  typedef struct {int due; logic [3:0] a; logic [15:0] d;} pb_t;
  typedef struct {logic oen; logic [3:0] oaddr; logic [15:0] odata; logic exp_mvalid; logic exp_err;} vec_t;
  vec_t tbl[7];

  fft_frame_ctrl #(.TOTAL_STAGE_P(TS), .MULT_WIDTH_P(MW), .MAX_INFLIGHT_P(MAXI)) dut (
    .iclk(iclk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_nframes(cfg_nframes),
    .cfg_inverse(cfg_inverse), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .fft_ien(fft_ien), .fft_iaddr(fft_iaddr), .fft_idata(fft_idata), .fft_oen(fft_oen),
    .fft_oaddr(fft_oaddr), .fft_odata(fft_odata), .m_valid(m_valid), .m_addr(m_addr),
    .m_data(m_data), .m_last(m_last), .busy(busy), .done(done), .err(err)
  );

  always #5 iclk = ~iclk;

  function automatic logic [15:0] sw(input logic [15:0] x, input bit inv);
    return (inv && IFFT) ? {x[7:0], x[15:8]} : x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", nm, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge iclk);
    #1;
    cyc++;
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_s_ready"}, s_ready, 0);
    chk({nm, "_ien"}, fft_ien, 0);
    chk({nm, "_iaddr"}, fft_iaddr, 0);
    chk({nm, "_idata"}, fft_idata, 0);
    chk({nm, "_mvalid"}, m_valid, 0);
    chk({nm, "_maddr"}, m_addr, 0);
    chk({nm, "_mdata"}, m_data, 0);
    chk({nm, "_mlast"}, m_last, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_err"}, err, 0);
  endtask

  task automatic run_frames(input int nf, input bit inv, input int lat, input int gap);
    int total, acc, ret, since;
    bit pi, po, pl, rdy;
    logic [3:0] pa, oa;
    logic [15:0] pd, od;
    pb_t pq[$];
    pb_t b;
    total = nf * N; acc = 0; ret = 0; since = -1;
    pi = 0; po = 0; pl = 0; pa = '0; pd = '0; oa = '0; od = '0;
    cfg_start = 1; cfg_nframes = 8'(nf); cfg_inverse = inv; s_valid = 0; fft_oen = 0;
    tick();
    cfg_start = 0;
    for (int n = 0; n < 4000 && since < 3; n++) begin
      chk("ien", fft_ien, pi);
      if (pi) begin
        chk("iaddr", fft_iaddr, pa);
        chk("idata", fft_idata, pd);
      end
      chk("mvalid", m_valid, po);
      if (po) begin
        chk("maddr", m_addr, oa);
        chk("mdata", m_data, sw(od, inv));
        chk("mlast", m_last, pl);
      end
      chk("done", done, since == 2);
      chk("busy", busy, since < 2);
      rdy = acc < total && !(acc % N == 0 && acc / N - ret / N >= MAXI);
      chk("s_ready", s_ready, rdy);
      s_valid = $urandom_range(99) >= gap;
      s_data = 16'($urandom);
      cfg_start = since < 2 && $urandom_range(49) == 0;
      cfg_nframes = 8'($urandom);
      pi = s_valid && rdy;
      if (pi) begin
        pa = 4'(acc % N);
        pd = sw(s_data, inv);
        pq.push_back('{cyc + lat, pa, pd});
        acc++;
      end
      po = pq.size() > 0 && pq[0].due <= cyc;
      fft_oen = po;
      if (po) begin
        b = pq.pop_front();
        oa = b.a;
        od = b.d ^ 16'h0f0f;
        fft_oaddr = oa;
        fft_odata = od;
        pl = ret % N == N - 1;
        ret++;
        if (ret == total) since = 0;
      end
      tick();
      if (since >= 0) since++;
    end
    checks++;
    if (since < 3) begin
      errors++;
      $display("FAIL run_timeout nf=%0d sent=%0d returned=%0d required=%0d", nf, acc, ret, total);
    end
    chk("run_err", err, 0);
    s_valid = 0; fft_oen = 0; cfg_start = 0;
  endtask

  initial begin
    tbl[0] = '{1'b1, 4'd0, 16'h1111, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 4'd1, 16'h2222, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 4'd2, 16'h3333, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 4'd3, 16'h4444, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 4'd5, 16'h5555, 1'b1, 1'b1};
    tbl[5] = '{1'b0, 4'd0, 16'h0000, 1'b0, 1'b1};
    tbl[6] = '{1'b1, 4'd5, 16'h6666, 1'b1, 1'b1};

    tick(); tick();
    chk_reset("por");
    rst_n = 1;
    tick();

    run_frames(1, 0, 40, 0);
    run_frames(4, 0, 48, 0);
    run_frames(3, 0, 16, 0);
    for (int i = 0; i < 5; i++)
      run_frames(int'($urandom_range(1, 5)), 1'($urandom), int'($urandom_range(1, 60)), 30);

    cfg_start = 1; cfg_nframes = 8'd1; cfg_inverse = 0;
    tick();
    cfg_start = 0;
    for (int i = 0; i < N; i++) begin
      chk("addr_feed_ready", s_ready, 1);
      s_valid = 1; s_data = 16'($urandom);
      tick();
    end
    s_valid = 0;
    tick();
    chk("addr_drain_busy", busy, 1);
    chk("addr_drain_ready", s_ready, 0);
    for (int i = 0; i < 7; i++) begin
      fft_oen = tbl[i].oen; fft_oaddr = tbl[i].oaddr; fft_odata = tbl[i].odata;
      tick();
      chk($sformatf("tbl%0d_mvalid", i), m_valid, tbl[i].exp_mvalid);
      if (tbl[i].exp_mvalid) begin
        chk($sformatf("tbl%0d_maddr", i), m_addr, tbl[i].oaddr);
        chk($sformatf("tbl%0d_mdata", i), m_data, tbl[i].odata);
      end
      chk($sformatf("tbl%0d_err", i), err, tbl[i].exp_err);
    end
    for (int a = 6; a < N; a++) begin
      fft_oen = 1; fft_oaddr = 4'(a); fft_odata = 16'(a);
      tick();
      chk("addr_tail_mlast", m_last, a == N - 1);
    end
    fft_oen = 0;
    tick();
    chk("addr_done", done, 1);
    chk("addr_idle", busy, 0);
    chk("addr_err_sticky", err, 1);
    cfg_start = 1; cfg_nframes = 8'd0;
    tick();
    cfg_start = 0;
    chk("zero_done", done, 1);
    chk("zero_err_clr", err, 0);
    chk("zero_busy", busy, 0);
    tick();
    chk("zero_done_pulse", done, 0);

    cfg_start = 1; cfg_nframes = 8'd2; cfg_inverse = 1;
    tick();
    cfg_start = 0;
    s_valid = 1; s_data = 16'h0307;
    tick();
    s_valid = 0;
    chk("ifft_ien", fft_ien, 1);
    chk("ifft_idata", fft_idata, IFFT ? 16'h0703 : 16'h0307);
    fft_oen = 1; fft_oaddr = 4'd0; fft_odata = 16'h0307;
    tick();
    fft_oen = 0;
    chk("ifft_mdata", m_data, IFFT ? 16'h0703 : 16'h0307);
    s_valid = 1;
    tick(); tick(); tick();
    s_valid = 0;
    chk("mid_busy", busy, 1);
    #2 rst_n = 0;
    #1 chk_reset("async");
    @(posedge iclk);
    #1 chk_reset("held");
    rst_n = 1;
    tick();
    fft_oen = 1; fft_oaddr = 4'd3; fft_odata = 16'habcd;
    tick();
    fft_oen = 0;
    chk("stray_err", err, 1);
    chk("stray_mvalid", m_valid, 1);
    chk("stray_maddr", m_addr, 3);
    chk("stray_mdata", m_data, 16'habcd);
    tick();
    chk("stray_err_sticky", err, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
